// File: rtl/bin_select_pkg.sv
// rtl/bin_select_pkg.sv - default widths and sample resize helper for the bin selector
package bin_select_pkg;

  localparam int DEF_I_BW       = 14;
  localparam int DEF_O_BW       = 14;
  localparam int DEF_IDX_W      = 10;
  localparam int DEF_GRP_W      = 7;
  localparam int DEF_FIFO_DEPTH = 4;

  // Clamp a sign-extended sample into o_bw bits when sat_en; caller keeps the low o_bw bits.
  function automatic logic signed [31:0] sat_resize(input logic signed [31:0] v,
                                                    input int unsigned o_bw,
                                                    input bit sat_en);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (o_bw - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (o_bw - 1));
    if (sat_en && (v > max_v)) return max_v;
    if (sat_en && (v < min_v)) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/bin_select_fifo.sv
// rtl/bin_select_fifo.sv - generic first-word-fall-through sync FIFO with registered full flag
module bin_select_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign empty      = (count == '0);
  assign pop_data   = mem[rd_ptr];

  // full is a flop: a pop in the full cycle only frees a slot from the next cycle on
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/bin_select_buffer.sv
// rtl/bin_select_buffer.sv - windowed FFT bin selector with FIFO output buffer
// Optional feature macro: BIN_SELECT_SAT_EN (saturate instead of wrap when narrowing).
module bin_select_buffer
  import bin_select_pkg::*;
#(
  parameter int I_BW       = DEF_I_BW,
  parameter int O_BW       = DEF_O_BW,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int GRP_W      = DEF_GRP_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    di_en,
  output logic                    di_ready,
  input  logic signed [I_BW-1:0]  data_i,
  input  logic [IDX_W-1:0]        in_group_idx,
  input  logic [GRP_W-1:0]        in_group_num,
  input  logic [IDX_W-1:0]        cfg_lo,
  input  logic [IDX_W-1:0]        cfg_hi,
  output logic                    do_en,
  input  logic                    do_ready,
  output logic signed [O_BW-1:0]  data_o,
  output logic [IDX_W-1:0]        out_group_idx,
  output logic [GRP_W-1:0]        out_group_num,
  output logic                    out_last,
  output logic                    overflow
);

  typedef struct packed {
    logic signed [O_BW-1:0] data;
    logic [IDX_W-1:0]       idx;
    logic [GRP_W-1:0]       num;
    logic                   last;
  } entry_t;

  localparam int                ENTRY_W = $bits(entry_t);
  localparam logic [IDX_W-1:0]  HI_DEF  = IDX_W'(2 ** (IDX_W - 1));
`ifdef BIN_SELECT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [IDX_W-1:0] lo_q, hi_q, win_lo, win_hi;
  logic             full, empty, accept, keep, first_bin;
  entry_t           wr_entry, rd_entry;
  logic [ENTRY_W-1:0] rd_bits;

  assign first_bin = (in_group_idx == '0);
  assign accept    = di_en & di_ready;
  // Bin 0 carries the new frame's window and is itself judged against it
  assign win_lo    = first_bin ? cfg_lo : lo_q;
  assign win_hi    = first_bin ? cfg_hi : hi_q;
  assign keep      = accept && (in_group_idx >= win_lo) && (in_group_idx <= win_hi);

  assign wr_entry.data = O_BW'(sat_resize(32'(data_i), O_BW, SAT_EN && (O_BW < I_BW)));
  assign wr_entry.idx  = in_group_idx;
  assign wr_entry.num  = in_group_num;
  assign wr_entry.last = (in_group_idx == win_hi);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q     <= '0;
      hi_q     <= HI_DEF;
      overflow <= 1'b0;
    end else begin
      if (accept && first_bin) begin
        lo_q <= cfg_lo;
        hi_q <= cfg_hi;
      end
      if (di_en && !di_ready) overflow <= 1'b1;
    end
  end

  bin_select_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data (wr_entry),
    .pop       (do_ready),
    .pop_data  (rd_bits),
    .full      (full),
    .empty     (empty)
  );

  assign rd_entry      = entry_t'(rd_bits);
  assign di_ready      = ~full;
  assign do_en         = ~empty;
  assign data_o        = rd_entry.data;
  assign out_group_idx = rd_entry.idx;
  assign out_group_num = rd_entry.num;
  assign out_last      = rd_entry.last;

endmodule

// File: tb/tb_bin_select_buffer.sv
// tb/tb_bin_select_buffer.sv - randomized bench for bin_select_buffer against a queue model
module tb_bin_select_buffer;

  localparam int I_BW  = 14;
  localparam int O_BW  = 8;
  localparam int IDX_W = 10;
  localparam int GRP_W = 7;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              di_en;
  logic              di_ready;
  logic [I_BW-1:0]   data_i;
  logic [IDX_W-1:0]  in_group_idx;
  logic [GRP_W-1:0]  in_group_num;
  logic [IDX_W-1:0]  cfg_lo;
  logic [IDX_W-1:0]  cfg_hi;
  logic              do_en;
  logic              do_ready;
  logic [O_BW-1:0]   data_o;
  logic [IDX_W-1:0]  out_group_idx;
  logic [GRP_W-1:0]  out_group_num;
  logic              out_last;
  logic              overflow;

  bin_select_buffer #(
    .I_BW(I_BW), .O_BW(O_BW), .IDX_W(IDX_W), .GRP_W(GRP_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .di_en(di_en), .di_ready(di_ready), .data_i(data_i),
    .in_group_idx(in_group_idx), .in_group_num(in_group_num), .cfg_lo(cfg_lo),
    .cfg_hi(cfg_hi), .do_en(do_en), .do_ready(do_ready), .data_o(data_o),
    .out_group_idx(out_group_idx), .out_group_num(out_group_num),
    .out_last(out_last), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [O_BW-1:0] data;
    int              idx;
    int              num;
    bit              last;
  } exp_t;

  exp_t q[$];
  int   win_lo, win_hi;
  bit   ovf_m;
  int   outs, lasts;
  int   checks, failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [O_BW-1:0] exp_data(input logic [I_BW-1:0] d);
    int v;
    v = int'($signed(d));
`ifdef BIN_SELECT_SAT_EN
    if (O_BW < I_BW) begin
      if (v > (1 << (O_BW - 1)) - 1) v = (1 << (O_BW - 1)) - 1;
      if (v < -(1 << (O_BW - 1)))    v = -(1 << (O_BW - 1));
    end
`endif
    return O_BW'(v);
  endfunction

  // One clock: check outputs against the model, drive inputs, then advance the model.
  task automatic step(input logic en, input int idx, input int num, input int d, input logic rdy);
    bit acc, pop;
    exp_t e;
    @(negedge clk);
    check("do_en", do_en, q.size() != 0);
    check("di_ready", di_ready, q.size() < DEPTH);
    check("overflow", overflow, ovf_m);
    if (q.size() != 0) begin
      check("data_o", data_o, q[0].data);
      check("out_idx", out_group_idx, q[0].idx);
      check("out_num", out_group_num, q[0].num);
      check("out_last", out_last, q[0].last);
    end
    di_en        = en;
    in_group_idx = IDX_W'(idx);
    in_group_num = GRP_W'(num);
    data_i       = I_BW'(d);
    do_ready     = rdy;
    acc = en && (q.size() < DEPTH);
    pop = (q.size() != 0) && rdy;
    if (en && !acc) ovf_m = 1'b1;
    if (pop) begin
      outs++;
      if (q[0].last) lasts++;
      void'(q.pop_front());
    end
    if (acc) begin
      if (idx == 0) begin
        win_lo = int'(cfg_lo);
        win_hi = int'(cfg_hi);
      end
      if (idx >= win_lo && idx <= win_hi) begin
        e.data = exp_data(I_BW'(d));
        e.idx  = idx;
        e.num  = num & ((1 << GRP_W) - 1);
        e.last = (idx == win_hi);
        q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  // Source advances to the next bin only when its sample was accepted.
  task automatic run_frame(input int n, input int lo, input int hi,
                           input int en_pct, input int rdy_pct, input int dfix);
    int  i, guard, d;
    bit  en, rdy, ready_now;
    i = 0;
    guard = 0;
    cfg_lo = IDX_W'(lo);
    cfg_hi = IDX_W'(hi);
    while (i < n && guard < 20 * n + 100) begin
      en  = ($urandom_range(0, 99) < en_pct);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      d   = (dfix >= 0) ? dfix : int'($urandom_range(0, (1 << I_BW) - 1));
      ready_now = (q.size() < DEPTH);
      step(en, i, int'($urandom_range(0, 127)), d, rdy);
      if (en && ready_now) i++;
      guard++;
    end
    if (i < n) check("frame_timeout", i, n);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 64) begin
      step(1'b0, 0, 0, 0, 1'b1);
      g++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    step(1'b0, 0, 0, 0, 1'b1);
  endtask

  initial begin
    int o0, l0;
    checks = 0; failures = 0; outs = 0; lasts = 0;
    rst = 1'b0; di_en = 1'b0; do_ready = 1'b0; data_i = '0;
    in_group_idx = '0; in_group_num = '0; cfg_lo = '0; cfg_hi = '0;
    win_lo = 0; win_hi = 512; ovf_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_do_en", do_en, 1'b0);
    check("rst_di_ready", di_ready, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    check("rst_data_o", data_o, 0);
    check("rst_out_idx", out_group_idx, 0);
    rst = 1'b1;

    // full frame, half spectrum window
    o0 = outs; l0 = lasts;
    run_frame(1024, 0, 512, 100, 100, -1);
    drain();
    check("t1_count", outs - o0, 513);
    check("t1_last", lasts - l0, 1);

    // narrow window 5..7
    o0 = outs; l0 = lasts;
    run_frame(16, 5, 7, 90, 80, -1);
    drain();
    check("t2_count", outs - o0, 3);
    check("t2_last", lasts - l0, 1);

    // inverted window, then 0..1
    o0 = outs;
    run_frame(16, 10, 3, 90, 80, -1);
    drain();
    check("t4_empty", outs - o0, 0);
    o0 = outs;
    run_frame(8, 0, 1, 90, 80, -1);
    drain();
    check("t4_next", outs - o0, 2);

    // narrowing: positive overrange, negative overrange, minus one
    run_frame(4, 0, 3, 100, 100, 14'h1FFF);
    run_frame(4, 0, 3, 100, 50, 14'h2000);
    run_frame(4, 0, 3, 100, 100, 14'h3FFF);
    drain();

    for (int f = 0; f < 20; f++) begin
      run_frame(48, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 80, 70, -1);
    end
    drain();

    // backpressure: six kept samples back to back with downstream stalled
    o0 = outs;
    cfg_lo = '0; cfg_hi = 10'd1023;
    for (int i = 0; i < 6; i++) step(1'b1, i, i, int'($urandom_range(0, 16383)), 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    check("t3_ovf", overflow, 1'b1);
    drain();
    check("t3_count", outs - o0, 4);

    // reset with three entries queued
    cfg_lo = '0; cfg_hi = 10'd512;
    for (int i = 0; i < 3; i++) step(1'b1, i, i, int'($urandom_range(0, 16383)), 1'b0);
    @(negedge clk);
    di_en = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_do_en", do_en, 1'b0);
    check("t6_overflow", overflow, 1'b0);
    check("t6_di_ready", di_ready, 1'b1);
    check("t6_data_o", data_o, 0);
    check("t6_out_last", out_last, 1'b0);
    q.delete();
    win_lo = 0; win_hi = 512; ovf_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cfg_lo = 10'd200; cfg_hi = 10'd300;
    // no bin 0 yet: default window must apply
    o0 = outs; l0 = lasts;
    step(1'b1, 600, 1, 100, 1'b1);
    step(1'b1, 100, 2, 200, 1'b1);
    step(1'b1, 512, 3, 300, 1'b1);
    step(1'b1, 513, 4, 400, 1'b1);
    drain();
    check("t6_default_count", outs - o0, 2);
    check("t6_default_last", lasts - l0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
